// File: rtl/array_7_ctrl_if.sv
// Request/response and SRAM-port bundle for array_7_ctrl.
// The slave modport is the controller; master is the requester/SRAM side.
interface array_7_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24,
    parameter int LANES  = 4
);
    logic              io_init_done;
    logic              io_r_req_valid;
    logic              io_r_req_ready;
    logic [ADDR_W-1:0] io_r_req_addr;
    logic              io_r_resp_valid;
    logic [DATA_W-1:0] io_r_resp_data;
    logic              io_w_req_valid;
    logic              io_w_req_ready;
    logic [ADDR_W-1:0] io_w_req_addr;
    logic [DATA_W-1:0] io_w_req_data;
    logic [LANES-1:0]  io_w_req_mask;
    logic              sram_R0_en;
    logic [ADDR_W-1:0] sram_R0_addr;
    logic [DATA_W-1:0] sram_R0_data;
    logic              sram_W0_en;
    logic [ADDR_W-1:0] sram_W0_addr;
    logic [DATA_W-1:0] sram_W0_data;
    logic [LANES-1:0]  sram_W0_mask;

    modport slave (
        output io_init_done, io_r_req_ready, io_r_resp_valid, io_r_resp_data,
        output io_w_req_ready,
        output sram_R0_en, sram_R0_addr, sram_W0_en, sram_W0_addr, sram_W0_data, sram_W0_mask,
        input  io_r_req_valid, io_r_req_addr,
        input  io_w_req_valid, io_w_req_addr, io_w_req_data, io_w_req_mask,
        input  sram_R0_data
    );

    modport master (
        input  io_init_done, io_r_req_ready, io_r_resp_valid, io_r_resp_data,
        input  io_w_req_ready,
        input  sram_R0_en, sram_R0_addr, sram_W0_en, sram_W0_addr, sram_W0_data, sram_W0_mask,
        output io_r_req_valid, io_r_req_addr,
        output io_w_req_valid, io_w_req_addr, io_w_req_data, io_w_req_mask,
        output sram_R0_data
    );
endinterface

// File: rtl/array_7_ctrl.sv
// Requester-side controller for the 256x24 masked-write BPU table SRAM: zero-fill sweep,
// read/write handshakes, one-entry write buffer. ARRAY7_CTRL_BYPASS_EN enables same-cycle write bypass.
module array_7_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24,
    parameter int LANES  = 4
) (
    input  logic           clock,
    input  logic           reset,
    array_7_ctrl_if.slave  io
);
    localparam int LANE_W = DATA_W / LANES;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              resp_vld_q, resp_vld_d;
    logic              wb_vld_q, wb_vld_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [LANES-1:0]  wb_mask_q, wb_mask_d;
    logic              r_fire, w_fire;

    assign r_fire = io.io_r_req_valid & io.io_r_req_ready;
    assign w_fire = io.io_w_req_valid & io.io_w_req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
        resp_vld_d = r_fire;
        wb_vld_d   = w_fire;
        wb_addr_d  = w_fire ? io.io_w_req_addr : wb_addr_q;
        wb_data_d  = w_fire ? io.io_w_req_data : wb_data_q;
        wb_mask_d  = w_fire ? io.io_w_req_mask : wb_mask_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            resp_vld_q  <= 1'b0;
            wb_vld_q    <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_mask_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            resp_vld_q  <= resp_vld_d;
            wb_vld_q    <= wb_vld_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_mask_q   <= wb_mask_d;
        end
    end

    // Reset gates the outputs combinationally so a buffered write or pending
    // response captured just before reset never reaches the SRAM or requester.
    assign io.io_init_done    = init_done_q;
    assign io.io_r_req_ready  = init_done_q & ~reset;
    assign io.io_w_req_ready  = init_done_q & ~reset;
    assign io.io_r_resp_valid = resp_vld_q & ~reset;

    assign io.sram_R0_en   = r_fire;
    assign io.sram_R0_addr = io.io_r_req_addr;
    assign io.sram_W0_en   = ~reset & ((state_q == INIT) | wb_vld_q);
    assign io.sram_W0_addr = (state_q == INIT) ? cnt_q : wb_addr_q;
    assign io.sram_W0_data = (state_q == INIT) ? '0    : wb_data_q;
    assign io.sram_W0_mask = (state_q == INIT) ? '1    : wb_mask_q;

`ifdef ARRAY7_CTRL_BYPASS_EN
    logic hit_q, hit_d;
    logic [DATA_W-1:0] resp_data;

    assign hit_d = r_fire & w_fire & (io.io_r_req_addr == io.io_w_req_addr);

    always_ff @(posedge clock) begin
        if (reset) hit_q <= 1'b0;
        else       hit_q <= hit_d;
    end

    // On a hit the buffer still holds the colliding write, so its masked lanes override the stale SRAM read.
    always_comb begin
        resp_data = io.sram_R0_data;
        for (int l = 0; l < LANES; l++)
            if (hit_q && wb_mask_q[l])
                resp_data[l*LANE_W +: LANE_W] = wb_data_q[l*LANE_W +: LANE_W];
    end

    assign io.io_r_resp_data = resp_data;
`else
    assign io.io_r_resp_data = io.sram_R0_data;
`endif
endmodule

// File: doc/array_7_ctrl.md
# array_7_ctrl

Requester-side controller for the 256×24 1R1W masked-write BPU table SRAM (4 lanes × 6 bits). Sits between predictor/update logic and the SRAM macro. Zero-fills the array after reset, accepts independent read and masked-write requests through valid/ready handshakes, drives the SRAM R0/W0 ports, and returns read data one cycle later with optional same-cycle write bypass.

## Interface
- ADDR_W, 8, entry address width (256 entries)
- DATA_W, 24, entry width
- LANES, 4, write-mask lanes; lane width = DATA_W/LANES = 6
- clock  in  1  single clock; also drives SRAM R0_clk/W0_clk externally
- reset  in  1  synchronous, active-high
- io_init_done  out  1  high once the zero-fill sweep completes
- io_r_req_valid  in  1  read request valid
- io_r_req_ready  out  1  read request accepted when valid&ready
- io_r_req_addr  in  ADDR_W  read address
- io_r_resp_valid  out  1  one-cycle pulse, read data valid
- io_r_resp_data  out  DATA_W  read data, meaningful only with resp_valid
- io_w_req_valid  in  1  write request valid
- io_w_req_ready  out  1  write request accepted when valid&ready
- io_w_req_addr  in  ADDR_W  write address
- io_w_req_data  in  DATA_W  write data
- io_w_req_mask  in  LANES  lane i enables bits [6i+5:6i]
- sram_R0_en / sram_R0_addr  out  1 / ADDR_W  SRAM read port
- sram_R0_data  in  DATA_W  SRAM read data (valid cycle after R0_en)
- sram_W0_en / sram_W0_addr / sram_W0_data / sram_W0_mask  out  1 / ADDR_W / DATA_W / LANES  SRAM write port

## Operation
- FSM states: INIT, RUN. Reset forces INIT, counter = 0.
- INIT: each cycle W0_en=1, W0_addr=counter, W0_data=0, W0_mask=4'hF; counter increments. After the addr-255 write, next state RUN. Both readies 0, R0_en 0.
- RUN: io_init_done=1, io_r_req_ready=1, io_w_req_ready=1 every cycle. Read and write may fire in the same cycle, any addresses.
- Read fire at cycle t: R0_en=1, R0_addr=io_r_req_addr combinationally in t. Registered resp_valid=1 at t+1; io_r_resp_data from sram_R0_data (plus bypass).
- Write fire at t: addr/data/mask captured in a one-entry write buffer; W0_en=1 with buffered fields in t+1. Buffer reloads every cycle; back-to-back writes sustain one per cycle.
- Write buffered at t-1 and issuing at t is visible to a read fired at t through the SRAM itself (write-then-registered-address read); no bypass needed.
- Read and write fire at t to the same address: SRAM output at t+1 holds pre-write data → hazard, handled per Configuration.
- Reset mid-operation (any state): buffered write dropped (no W0_en next cycle beyond INIT sweep), pending resp_valid cleared, sweep restarts at address 0.

## Timing
- Reset values: io_init_done 0, both readies 0, io_r_resp_valid 0, sram_R0_en 0, write buffer invalid. First cycle after reset deasserts: W0_en=1, addr 0.
- INIT lasts 256 cycles; io_init_done and readies rise on cycle 257 after reset deassert.
- Read latency: request to response exactly 1 cycle; no response backpressure.
- Write latency: accept to SRAM write 1 cycle; readable by a read fired the same cycle the write issues (2-cycle write-to-read visibility from accept without bypass).

## Configuration
- ARRAY7_CTRL_BYPASS_EN defined: register a hit flag (read addr == write addr, both fired at t). At t+1, for each lane with buffered mask bit set, io_r_resp_data lane = buffered write data lane; other lanes from sram_R0_data. Reads return post-write data.
- Undefined: io_r_resp_data = sram_R0_data unconditionally; same-cycle same-address read returns old data. No hit logic compiled.

## Test plan
- Reset, hold 0 requests 300 cycles -> W0_en high exactly 256 cycles, addresses 0..255, data 0, mask F; init_done rises cycle 257; reads of 0x00, 0xFF return 24'h0.
- Write addr 0x12 data 24'hABCDEF mask F; read 0x12 two cycles later -> resp_valid one cycle after read, data 24'hABCDEF.
- Write 0x12 data 24'hFFFFFF mask 4'b0101 over 24'h0 -> later read returns 24'h03F03F.
- Same cycle: read and write 0x34 data 24'h123456 mask F, prior content 0 -> with BYPASS_EN resp 24'h123456; without, 24'h000000; following read 24'h123456 either way.
- Back-to-back writes 0x00..0x07 data=addr, then reads each -> one W0_en per cycle, reads return 0..7.
- Assert reset mid-RUN with write in buffer -> no stray write to buffered address, resp_valid 0, sweep restarts at 0, previously written 0x12 reads 0 after init.
